relu_layer_ctrl: RTL and testbench

Sequencer that time-shares one multiply-accumulate register and the ReLU stage across NEURONS output neurons of a fully connected layer, each with TAPS inputs. It fetches activations and weights by address, accumulates into an 11-bit signed sum, drives that sum to the ReLU stage, and captures the 8-bit rectified result. The result is then offered on a valid/ready port. The block sits between the activation/weight register files and the next layer's input buffer.

---
 rtl/relu_ctrl_pkg.sv | 18 +
 rtl/mac_acc.sv | 37 +++
 rtl/relu_layer_ctrl.sv | 120 ++++++++++++
 tb/tb_relu_layer_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/relu_ctrl_pkg.sv
// Shared widths and FSM state type for the time-shared MAC/ReLU layer sequencer.
package relu_ctrl_pkg;

    localparam int X_W    = 4;
    localparam int W_W    = 4;
    localparam int PROD_W = 9;
    localparam int ACC_W  = 11;
    localparam int OUT_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        RELU,
        OUT
    } state_t;

endpackage

// File: rtl/mac_acc.sv
// Multiply-accumulate register: unsigned activation times signed weight,
// sign-extended and summed into a non-saturating signed accumulator.
module mac_acc
    import relu_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic [X_W-1:0]          x,
    input  logic signed [W_W-1:0]   w,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [ACC_W-1:0] acc_p0;

    // Activation gets a zero sign bit so the product is a true 4u x 4s multiply.
    function automatic logic signed [ACC_W-1:0] mul_sext(
        input logic [X_W-1:0]        a,
        input logic signed [W_W-1:0] b
    );
        logic signed [PROD_W-1:0] p;
        p = PROD_W'($signed({1'b0, a})) * PROD_W'(b);
        return ACC_W'(p);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_p0 <= '0;
        end else if (en) begin
            acc_p0 <= acc_p0 + mul_sext(x, w);
        end
    end

    assign acc = acc_p0;

endmodule

// File: rtl/relu_layer_ctrl.sv
// Sequencer sharing one MAC accumulator and an external ReLU stage across all
// neurons of a fully connected layer; results leave on a valid/ready port.
module relu_layer_ctrl
    import relu_ctrl_pkg::*;
#(
    parameter  int TAPS    = 8,
    parameter  int NEURONS = 4,
    localparam int XA_W    = (TAPS > 1) ? $clog2(TAPS) : 1,
    localparam int WA_W    = (NEURONS * TAPS > 1) ? $clog2(NEURONS * TAPS) : 1,
    localparam int NI_W    = (NEURONS > 1) ? $clog2(NEURONS) : 1
)(
    input  logic             CLK,
    input  logic             RST,
    input  logic             VDD,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic [XA_W-1:0]  X_ADDR,
    output logic [WA_W-1:0]  W_ADDR,
    input  logic [X_W-1:0]   X_DATA,
    input  logic [W_W-1:0]   W_DATA,
    output logic [ACC_W-1:0] ACC,
    input  logic [OUT_W-1:0] RELU_Y,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [OUT_W-1:0] OUT_DATA,
    output logic [NI_W-1:0]  OUT_IDX
);

    state_t                  state, state_nxt;
    logic [XA_W-1:0]         tap;
    logic [NI_W-1:0]         neuron;
    logic [OUT_W-1:0]        out_data_p0;
    logic [NI_W-1:0]         out_idx_p0;
    logic                    done_p0;
    logic                    mac_clr, mac_en;
    logic                    last_tap, last_neuron, accept;
    logic signed [ACC_W-1:0] acc;

    // The supply pin has no function in RTL; it is only meaningful in the netlist.
    logic unused_vdd;
    assign unused_vdd = VDD;

    assign last_tap    = (tap == XA_W'(TAPS - 1));
    assign last_neuron = (neuron == NI_W'(NEURONS - 1));
    assign accept      = (state == OUT) && OUT_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = CLEAR;
            CLEAR:   state_nxt = ACCUM;
            ACCUM:   if (last_tap) state_nxt = RELU;
            RELU:    state_nxt = OUT;
            OUT:     if (OUT_READY) state_nxt = last_neuron ? IDLE : CLEAR;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BUSY      = 1'b0;
        OUT_VALID = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        BUSY      = (state != IDLE);
        OUT_VALID = (state == OUT);
        mac_clr   = (state == CLEAR);
        mac_en    = (state == ACCUM);
    end

    // Tap wraps to 0 after the last tap so addresses stay frozen while the result waits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tap         <= '0;
            neuron      <= '0;
            out_data_p0 <= '0;
            out_idx_p0  <= '0;
            done_p0     <= 1'b0;
        end else begin
            done_p0 <= accept && last_neuron;
            case (state)
                IDLE:  if (START) neuron <= '0;
                CLEAR: tap <= '0;
                ACCUM: tap <= last_tap ? '0 : tap + 1'b1;
                RELU: begin
                    out_data_p0 <= RELU_Y;
                    out_idx_p0  <= neuron;
                end
                OUT: if (OUT_READY) neuron <= last_neuron ? '0 : neuron + 1'b1;
                default: ;
            endcase
        end
    end

    mac_acc u_mac (
        .clk (CLK),
        .rst (RST),
        .clr (mac_clr),
        .en  (mac_en),
        .x   (X_DATA),
        .w   ($signed(W_DATA)),
        .acc (acc)
    );

    assign X_ADDR   = tap;
    assign W_ADDR   = WA_W'(neuron) * WA_W'(TAPS) + WA_W'(tap);
    assign ACC      = acc;
    assign OUT_DATA = out_data_p0;
    assign OUT_IDX  = out_idx_p0;
    assign DONE     = done_p0;

endmodule

// File: tb/tb_relu_layer_ctrl.sv
// Bench for relu_layer_ctrl: an 8-tap/2-neuron instance driven by tables, hand
// sequences and random passes, plus a 1-tap/1-neuron instance for the edge sizes.
module tb_relu_layer_ctrl;

    localparam int TA = 8;
    localparam int NA = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic RST = 1'b1;
    logic VDD = 1'b1;

    // Instance A: TAPS=8, NEURONS=2
    logic              START_a = 1'b0, OUT_READY_a = 1'b0;
    logic              BUSY_a, DONE_a, OUT_VALID_a;
    logic [2:0]        X_ADDR_a;
    logic [3:0]        W_ADDR_a;
    logic [3:0]        X_DATA_a, W_DATA_a;
    logic signed [10:0] ACC_a;
    logic [7:0]        RELU_Y_a, OUT_DATA_a;
    logic [0:0]        OUT_IDX_a;

    // Instance B: TAPS=1, NEURONS=1
    logic              START_b = 1'b0, OUT_READY_b = 1'b0;
    logic              BUSY_b, DONE_b, OUT_VALID_b;
    logic [0:0]        X_ADDR_b, W_ADDR_b, OUT_IDX_b;
    logic [3:0]        X_DATA_b, W_DATA_b;
    logic signed [10:0] ACC_b;
    logic [7:0]        RELU_Y_b, OUT_DATA_b;

    int xa [TA];
    int wa [NA*TA];
    int exp_acc [NA];
    int exp_y [NA];
    int xb = 0, wb = 0;

    int n_chk = 0;
    int n_fail = 0;

    // Register-file and ReLU-stage models around the DUTs.
    assign X_DATA_a = 4'(xa[X_ADDR_a]);
    assign W_DATA_a = 4'(wa[W_ADDR_a]);
    assign RELU_Y_a = ACC_a[10] ? 8'd0 : ACC_a[9:2];
    assign X_DATA_b = 4'(xb);
    assign W_DATA_b = 4'(wb);
    assign RELU_Y_b = ACC_b[10] ? 8'd0 : ACC_b[9:2];

    relu_layer_ctrl #(.TAPS(TA), .NEURONS(NA)) dut_a (
        .CLK(clk), .RST(RST), .VDD(VDD), .START(START_a), .BUSY(BUSY_a), .DONE(DONE_a),
        .X_ADDR(X_ADDR_a), .W_ADDR(W_ADDR_a), .X_DATA(X_DATA_a), .W_DATA(W_DATA_a),
        .ACC(ACC_a), .RELU_Y(RELU_Y_a), .OUT_VALID(OUT_VALID_a), .OUT_READY(OUT_READY_a),
        .OUT_DATA(OUT_DATA_a), .OUT_IDX(OUT_IDX_a)
    );

    relu_layer_ctrl #(.TAPS(1), .NEURONS(1)) dut_b (
        .CLK(clk), .RST(RST), .VDD(VDD), .START(START_b), .BUSY(BUSY_b), .DONE(DONE_b),
        .X_ADDR(X_ADDR_b), .W_ADDR(W_ADDR_b), .X_DATA(X_DATA_b), .W_DATA(W_DATA_b),
        .ACC(ACC_b), .RELU_Y(RELU_Y_b), .OUT_VALID(OUT_VALID_b), .OUT_READY(OUT_READY_b),
        .OUT_DATA(OUT_DATA_b), .OUT_IDX(OUT_IDX_b)
    );

    typedef struct {
        int x; int w0; int w1;
        int acc0; int acc1; int y0; int y1;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: dot product per neuron, then rectify and drop the two LSBs.
    function automatic void model();
        for (int n = 0; n < NA; n++) begin
            int s;
            s = 0;
            for (int t = 0; t < TA; t++) s += xa[t] * wa[n*TA + t];
            exp_acc[n] = s;
            exp_y[n]   = (s < 0) ? 0 : s / 4;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pass(input int stall, input bit early, input bit glitch);
        int xs, ws;
        START_a = 1'b1;
        step();
        START_a = 1'b0;
        check("busy_after_start", int'(BUSY_a), 1);
        check("done_low_at_clear", int'(DONE_a), 0);
        for (int n = 0; n < NA; n++) begin
            OUT_READY_a = early;
            for (int i = 1; i <= TA + 2; i++) begin
                step();
                START_a = glitch && (n == 0) && (i == 3);
                if (i <= TA) begin
                    check("x_addr", int'(X_ADDR_a), i - 1);
                    check("w_addr", int'(W_ADDR_a), n*TA + i - 1);
                    check("valid_low_accum", int'(OUT_VALID_a), 0);
                end else if (i == TA + 1) begin
                    check("acc_at_relu", int'(ACC_a), exp_acc[n]);
                    check("valid_low_relu", int'(OUT_VALID_a), 0);
                end
            end
            check("out_valid", int'(OUT_VALID_a), 1);
            check("out_data", int'(OUT_DATA_a), exp_y[n]);
            check("out_idx", int'(OUT_IDX_a), n);
            check("acc_hold_out", int'(ACC_a), exp_acc[n]);
            xs = int'(X_ADDR_a);
            ws = int'(W_ADDR_a);
            if (!early) begin
                for (int s = 0; s < stall; s++) begin
                    step();
                    check("stall_valid", int'(OUT_VALID_a), 1);
                    check("stall_data", int'(OUT_DATA_a), exp_y[n]);
                    check("stall_idx", int'(OUT_IDX_a), n);
                    check("stall_acc", int'(ACC_a), exp_acc[n]);
                    check("stall_x_addr", int'(X_ADDR_a), xs);
                    check("stall_w_addr", int'(W_ADDR_a), ws);
                end
                OUT_READY_a = 1'b1;
            end
            step();
            OUT_READY_a = 1'b0;
            if (n < NA - 1) begin
                check("busy_next_neuron", int'(BUSY_a), 1);
                check("valid_low_clear", int'(OUT_VALID_a), 0);
                check("no_early_done", int'(DONE_a), 0);
            end else begin
                check("done_pulse", int'(DONE_a), 1);
                check("busy_low_done", int'(BUSY_a), 0);
                check("valid_low_done", int'(OUT_VALID_a), 0);
            end
        end
    endtask

    task automatic run_b(input int x, input int w, input int eacc, input int ey);
        xb = x;
        wb = w;
        START_b = 1'b1;
        step();
        START_b = 1'b0;
        check("b_busy", int'(BUSY_b), 1);
        check("b_done_low", int'(DONE_b), 0);
        step();
        check("b_x_addr", int'(X_ADDR_b), 0);
        check("b_w_addr", int'(W_ADDR_b), 0);
        check("b_valid_low", int'(OUT_VALID_b), 0);
        step();
        check("b_acc_relu", int'(ACC_b), eacc);
        step();
        check("b_out_valid", int'(OUT_VALID_b), 1);
        check("b_out_data", int'(OUT_DATA_b), ey);
        check("b_out_idx", int'(OUT_IDX_b), 0);
        OUT_READY_b = 1'b1;
        step();
        OUT_READY_b = 1'b0;
        check("b_done", int'(DONE_b), 1);
        check("b_busy_low", int'(BUSY_b), 0);
    endtask

    task automatic set_ramp();
        for (int t = 0; t < TA; t++) begin
            xa[t]      = t + 1;
            wa[t]      = 1;
            wa[TA + t] = 2;
        end
    endtask

    initial begin
        vec_t tbl [6];
        tbl[0] = '{15,  7,  7,  840,  840, 210, 210};
        tbl[1] = '{ 3, -2, -2,  -48,  -48,   0,   0};
        tbl[2] = '{15, -8, -8, -960, -960,   0,   0};
        tbl[3] = '{ 1,  1, -1,    8,   -8,   2,   0};
        tbl[4] = '{15,  7, -1,  840, -120, 210,   0};
        tbl[5] = '{ 5,  3,  0,  120,    0,  30,   0};

        repeat (3) step();
        check("rst_busy", int'(BUSY_a), 0);
        check("rst_done", int'(DONE_a), 0);
        check("rst_valid", int'(OUT_VALID_a), 0);
        check("rst_acc", int'(ACC_a), 0);
        check("rst_out_data", int'(OUT_DATA_a), 0);
        check("rst_out_idx", int'(OUT_IDX_a), 0);
        check("rst_x_addr", int'(X_ADDR_a), 0);
        check("rst_w_addr", int'(W_ADDR_a), 0);
        RST = 1'b0;
        step();
        check("idle_busy", int'(BUSY_a), 0);

        foreach (tbl[r]) begin
            for (int t = 0; t < TA; t++) begin
                xa[t]      = tbl[r].x;
                wa[t]      = tbl[r].w0;
                wa[TA + t] = tbl[r].w1;
            end
            exp_acc[0] = tbl[r].acc0;
            exp_acc[1] = tbl[r].acc1;
            exp_y[0]   = tbl[r].y0;
            exp_y[1]   = tbl[r].y1;
            run_pass(r % 3, 1'b0, 1'b0);
        end

        // Ramp activations with a 5-cycle stall and a START pulse mid-accumulation.
        set_ramp();
        exp_acc[0] = 36; exp_acc[1] = 72;
        exp_y[0]   = 9;  exp_y[1]   = 18;
        run_pass(5, 1'b0, 1'b1);

        // Abort in the middle of neuron 1.
        START_a = 1'b1;
        step();
        START_a = 1'b0;
        repeat (TA + 2) step();
        check("abort_pre_valid", int'(OUT_VALID_a), 1);
        OUT_READY_a = 1'b1;
        step();
        OUT_READY_a = 1'b0;
        repeat (4) step();
        check("abort_mid_busy", int'(BUSY_a), 1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("abort_busy", int'(BUSY_a), 0);
        check("abort_valid", int'(OUT_VALID_a), 0);
        check("abort_done", int'(DONE_a), 0);
        check("abort_acc", int'(ACC_a), 0);
        check("abort_out_data", int'(OUT_DATA_a), 0);
        check("abort_out_idx", int'(OUT_IDX_a), 0);
        check("abort_w_addr", int'(W_ADDR_a), 0);
        repeat (3) begin
            step();
            check("abort_no_done", int'(DONE_a), 0);
        end
        run_pass(0, 1'b0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            for (int t = 0; t < TA; t++) xa[t] = int'($urandom_range(15));
            for (int j = 0; j < NA*TA; j++) wa[j] = int'($urandom_range(15)) - 8;
            model();
            run_pass(int'($urandom_range(3)), 1'($urandom_range(1)), 1'b0);
        end

        run_b(15,  7,  105, 26);
        run_b(15, -8, -120,  0);
        run_b( 3, -2,   -6,  0);
        run_b( 4,  1,    4,  1);
        step();
        check("b_done_single", int'(DONE_b), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
